// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner: pad-side front end between the SCL/SDA pads and the I2C core.
//   Synchronises and glitch-filters SCL/SDA, reports SCL edges, START/STOP and bus
//   busy, and turns the core's pull-low requests into open-drain output enables.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   scl_pin_in, sda_pin_in    raw pad inputs
//   sda_drive_low             core asks to pull SDA low
//   scl_stretch               core asks to hold SCL low
//   scl_f, sda_f              filtered levels
//   scl_rise, scl_fall        one-cycle SCL edge strobes
//   start_det, stop_det       one-cycle START / STOP strobes
//   bus_busy                  high between START and STOP
//   sda_oe, scl_oe            pad output enables (pad data tied 0)
module i2c_bus_conditioner #(
   parameter int unsigned FILTER_LEN  = 3,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_pin_in,
   input  logic sda_pin_in,
   input  logic sda_drive_low,
   input  logic scl_stretch,
   output logic scl_f,
   output logic sda_f,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic bus_busy,
   output logic sda_oe,
   output logic scl_oe
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned NLINE = 2;
   localparam int unsigned SCL   = 0;
   localparam int unsigned SDA   = 1;

   logic [NLINE-1:0]            pin_raw;
   logic [NLINE-1:0]            sync1;
   logic [NLINE-1:0]            sync2;
   logic [NLINE-1:0]            filt;
   logic [NLINE-1:0]            filt_d;
   logic [NLINE-1:0][CNT_W-1:0] flt_cnt;
   logic [CNT_W-1:0]            hold_cnt;
   logic [CNT_W-1:0]            hold_nxt;

   assign pin_raw = {sda_pin_in, scl_pin_in};

   // Two-flop synchroniser, majority-free run-length filter and delayed copies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= '1;
         sync2   <= '1;
         filt    <= '1;
         filt_d  <= '1;
         flt_cnt <= '0;
      end else begin
         sync1  <= pin_raw;
         sync2  <= sync1;
         filt_d <= filt;
         for (int i = 0; i < int'(NLINE); i++) begin
            if (sync2[i] == filt[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
               filt[i]    <= ~filt[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign scl_f = filt[SCL];
   assign sda_f = filt[SDA];

   // Strobes decode the current and one-cycle-old filtered levels; a START/STOP
   // needs SCL high in both, so a simultaneous SCL/SDA flip reports only the edge.
   assign scl_rise  =  filt[SCL] & ~filt_d[SCL];
   assign scl_fall  = ~filt[SCL] &  filt_d[SCL];
   assign start_det =  filt_d[SDA] & ~filt[SDA] & filt[SCL] & filt_d[SCL];
   assign stop_det  = ~filt_d[SDA] &  filt[SDA] & filt[SCL] & filt_d[SCL];

   // Hold counter: reloaded on every SCL fall, counts down to zero.
   always_comb begin
      hold_nxt = hold_cnt;
      if (scl_fall) begin
         hold_nxt = CNT_W'(HOLD_CYCLES);
      end else if (hold_cnt != '0) begin
         hold_nxt = hold_cnt - CNT_W'(1);
      end
   end

   // Bus state, SDA drive (frozen while a hold runs) and SCL stretch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_busy <= 1'b0;
         hold_cnt <= '0;
         sda_oe   <= 1'b0;
         scl_oe   <= 1'b0;
      end else begin
         if (start_det) begin
            bus_busy <= 1'b1;
         end else if (stop_det) begin
            bus_busy <= 1'b0;
         end

         hold_cnt <= hold_nxt;
         // The request is taken on the edge where the hold expires, not one later.
         if (hold_nxt == '0) begin
            sda_oe <= sda_drive_low;
         end

         // Never start pulling SCL while it is high: that would shorten the
         // controller's high phase rather than stretch the low phase.
         if (!scl_stretch) begin
            scl_oe <= 1'b0;
         end else if (!filt[SCL]) begin
            scl_oe <= 1'b1;
         end
      end
   end

endmodule
